// File: rtl/fx_seq_mult.sv
// Sequential signed fixed-point shift-add multiplier (one multiplier bit per clock).
// Optional macro FX_MULT_SAT_EN: saturate out-of-range products instead of wrapping.
module fx_seq_mult #(
  parameter int W    = 19,
  parameter int FRAC = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = (W > 1) ? $clog2(W + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    count_r;
  logic [2*W-1:0]   acc_r;
  logic [2*W-1:0]   mcand_r;
  logic [W-1:0]     mplier_r;
  logic             sign_r;
  logic [W-1:0]     p_r;
  logic             done_r;
  logic [2*W-1:0]   m_s;
  logic [W-1:0]     result_s;

  // Unsigned magnitude; the most negative value maps to 2^(W-1), which still fits in W bits.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v[W-1]) r = ~v + {{(W-1){1'b0}}, 1'b1};
    else        r = v;
    return r;
  endfunction

  // Apply sign to the rescaled magnitude, with optional saturation.
  function automatic logic [W-1:0] apply_sign(input logic [2*W-1:0] m, input logic neg);
    logic [W-1:0] r;
`ifdef FX_MULT_SAT_EN
    logic [2*W-1:0] lim;
    logic [2*W-1:0] max_pos;
    lim     = {{(2*W-1){1'b0}}, 1'b1} << (W - 1);
    max_pos = lim - {{(2*W-1){1'b0}}, 1'b1};
    if (!neg && (m > max_pos))    r = {1'b0, {(W-1){1'b1}}};
    else if (neg && (m > lim))    r = {1'b1, {(W-1){1'b0}}};
    else if (neg)                 r = ~m[W-1:0] + {{(W-1){1'b0}}, 1'b1};
    else                          r = m[W-1:0];
`else
    if (neg) r = ~m[W-1:0] + {{(W-1){1'b0}}, 1'b1};
    else     r = m[W-1:0];
`endif
    return r;
  endfunction

  assign m_s      = acc_r >> FRAC;
  assign result_s = apply_sign(m_s, sign_r);

`ifndef FX_MULT_SAT_EN
  // High magnitude bits are deliberately discarded by the modular wrap.
  logic unused_m_s;
  assign unused_m_s = ^m_s[2*W-1:W];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic; the last add happens while count is W-1.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (count_r == CW'(W - 1)) state_s = FIX;
        else                       state_s = RUN;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add accumulation, rescale and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      sign_r   <= 1'b0;
      p_r      <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= {{W{1'b0}}, magnitude(a)};
            mplier_r <= magnitude(b);
            sign_r   <= a[W-1] ^ b[W-1];
            acc_r    <= '0;
            count_r  <= '0;
          end
        end
        RUN: begin
          // mcand_r holds |a| << count, mplier_r[0] is |b|[count].
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CW'(1);
        end
        FIX: begin
          p_r     <= result_s;
          done_r  <= 1'b1;
          count_r <= '0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state_r == RUN) || (state_r == FIX);
  assign done = done_r;
  assign p    = p_r;

endmodule
